// File: rtl/xor_shift_pkg.sv
// Shared types for the XOR/conditional-shift datapath family.
package xor_shift_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_CSHL = 2'b01,
        MODE_ROTL = 2'b10,
        MODE_ACC  = 2'b11
    } mode_t;

    // Width-independent part of the stage-1 record; the x/shamt fields are
    // sized by each instantiating module and wrap this control struct.
    typedef struct packed {
        logic  msb;
        mode_t mode;
    } s1_ctrl_t;

endpackage

// File: rtl/xor_shift_alu.sv
// Stage-2 result mux: pass, conditional shift-left, rotate-left, XOR accumulate.
// Purely combinational, no latency, no flow control.
module xor_shift_alu
    import xor_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic             msb_i,
    input  mode_t            mode_i,
    input  logic [SH_W-1:0]  shamt_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] c_o,
    output logic [WIDTH-1:0] acc_new_o
);

    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   acc_new;

    // Upper half of the doubled word shifted left is the left rotation.
    assign dbl       = {x_i, x_i} << shamt_i;
    assign acc_new   = acc_i ^ x_i;
    assign acc_new_o = acc_new;

    always_comb begin
        c_o = x_i;
        case (mode_i)
            MODE_PASS: c_o = x_i;
            MODE_CSHL: c_o = msb_i ? (x_i << shamt_i) : x_i;
            MODE_ROTL: c_o = dbl[2*WIDTH-1:WIDTH];
            MODE_ACC:  c_o = acc_new;
            default:   c_o = x_i;
        endcase
    end

endmodule

// File: rtl/xor_shift_pipe.sv
// Two-stage stallable XOR/shift pipeline with running accumulator and op counter.
// Latency 2 cycles, 1 beat/cycle; in_ready falls only when both stages are full and stalled.
module xor_shift_pipe
    import xor_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic [SH_W-1:0]  shamt,
    input  logic             clear_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [SH_W-1:0]  shamt;
        s1_ctrl_t         ctrl;
    } s1_t;

    s1_t              s1_q, s1_d;
    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_load;
    logic             s1_load;
    logic             accept;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] alu_c;
    logic [WIDTH-1:0] alu_acc;

    assign s2_load  = s1_vld_q && (!out_vld_q || out_ready);
    assign s1_load  = !s1_vld_q || s2_load;
    assign accept   = in_valid && s1_load;
    // Clear takes effect before any ACC combine in the same cycle.
    assign acc_base = clear_acc ? '0 : acc_q;

    xor_shift_alu #(
        .WIDTH (WIDTH),
        .SH_W  (SH_W)
    ) u_alu (
        .x_i       (s1_q.x),
        .msb_i     (s1_q.ctrl.msb),
        .mode_i    (s1_q.ctrl.mode),
        .shamt_i   (s1_q.shamt),
        .acc_i     (acc_base),
        .c_o       (alu_c),
        .acc_new_o (alu_acc)
    );

    always_comb begin
        s1_d      = s1_q;
        s1_vld_d  = s1_vld_q;
        c_d       = c_q;
        out_vld_d = out_vld_q;
        acc_d     = acc_base;
        cnt_d     = cnt_q;

        if (s1_load) begin
            s1_vld_d = in_valid;
        end
        if (accept) begin
            s1_d.x         = a ^ b;
            s1_d.shamt     = shamt;
            s1_d.ctrl.msb  = a[WIDTH-1];
            s1_d.ctrl.mode = mode_t'(mode);
        end

        if (s2_load) begin
            c_d       = alu_c;
            out_vld_d = 1'b1;
            if (s1_q.ctrl.mode == MODE_ACC) begin
                acc_d = alu_acc;
            end
        end else if (out_ready) begin
            out_vld_d = 1'b0;
        end

        if (out_vld_q && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s1_vld_q  <= 1'b0;
            c_q       <= '0;
            out_vld_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s1_vld_q  <= s1_vld_d;
            c_q       <= c_d;
            out_vld_q <= out_vld_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready  = s1_load;
    assign out_valid = out_vld_q;
    assign c         = c_q;
    assign acc       = acc_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_xor_shift_pipe.sv
// Bench for xor_shift_pipe: directed vectors, backpressure, random traffic vs model, async reset.
module tb_xor_shift_pipe;
    import xor_shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready, in_ready_s;
    logic [7:0] a, b;
    logic [1:0] mode;
    logic [2:0] shamt;
    logic       clear_acc;
    logic       out_valid, out_valid_s;
    logic       out_ready;
    logic [7:0] c, c_s, acc, acc_s;
    logic [7:0] op_count;
    logic [1:0] op_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor_shift_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .shamt(shamt), .clear_acc(clear_acc),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .acc(acc),
        .op_count(op_count)
    );

    xor_shift_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .mode(mode), .shamt(shamt), .clear_acc(clear_acc),
        .out_valid(out_valid_s), .out_ready(out_ready), .c(c_s), .acc(acc_s),
        .op_count(op_count_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the mode rules applied with plain integer arithmetic.
    function automatic logic [7:0] ref_c(input logic [7:0] ra, input logic [7:0] rb,
                                         input logic [1:0] rm, input int n,
                                         input logic [7:0] racc);
        int x;
        x = int'(ra ^ rb);
        case (rm)
            2'd1:    return (ra >= 8'd128) ? 8'((x * (1 << n)) % 256) : 8'(x);
            2'd2:    return 8'(((x * (1 << n)) + (x / (1 << (8 - n)))) % 256);
            2'd3:    return racc ^ 8'(x);
            default: return 8'(x);
        endcase
    endfunction

    typedef struct {
        logic [7:0] a, b;
        logic [1:0] mode;
        logic [2:0] sh;
        logic       clr;
        logic [7:0] exp_c, exp_acc;
    } vec_t;

    vec_t vt[14];

    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        bit  got;
        @(posedge clk); #1;
        in_valid = 1'b1; a = v.a; b = v.b; mode = v.mode; shamt = v.sh; out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("vec%0d in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = 8'h00; b = 8'h00; clear_acc = v.clr;
        n = 0; got = 0;
        while (!got && n < 8) begin
            if (n > 0) begin
                @(posedge clk); #1;
                clear_acc = 1'b0;
            end
            @(negedge clk);
            n++;
            if (out_valid) got = 1;
        end
        clear_acc = 1'b0;
        chk($sformatf("vec%0d latency", idx), n, 2);
        chk($sformatf("vec%0d c", idx), c, v.exp_c);
        chk($sformatf("vec%0d acc", idx), acc, v.exp_acc);
        chk($sformatf("vec%0d op_count", idx), op_count, idx);
        chk($sformatf("vec%0d op_count_sat", idx), op_count_s, (idx > 3) ? 3 : idx);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_bp[4];
        logic [7:0] q[$];
        logic [7:0] model_acc, prev_c, exp_v;
        int  n_acc, n_out, cyc, first_cyc, last_cyc;
        bit  prev_stall, seen_out;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = '0; shamt = '0;
        clear_acc = 1'b0; out_ready = 1'b0;

        //            a      b      mode  sh  clr  c      acc
        vt[0]  = '{8'h55, 8'h33, 2'd1, 3'd1, 1'b0, 8'h66, 8'h00};
        vt[1]  = '{8'hD5, 8'h33, 2'd1, 3'd1, 1'b0, 8'hCC, 8'h00};
        vt[2]  = '{8'hFF, 8'hFF, 2'd1, 3'd1, 1'b0, 8'h00, 8'h00};
        vt[3]  = '{8'h81, 8'h00, 2'd2, 3'd1, 1'b0, 8'h03, 8'h00};
        vt[4]  = '{8'h01, 8'h00, 2'd2, 3'd7, 1'b0, 8'h80, 8'h00};
        vt[5]  = '{8'h80, 8'h01, 2'd1, 3'd7, 1'b0, 8'h80, 8'h00};
        vt[6]  = '{8'h80, 8'h01, 2'd1, 3'd0, 1'b0, 8'h81, 8'h00};
        vt[7]  = '{8'h81, 8'h00, 2'd2, 3'd0, 1'b0, 8'h81, 8'h00};
        vt[8]  = '{8'h0F, 8'h00, 2'd3, 3'd0, 1'b0, 8'h0F, 8'h0F};
        vt[9]  = '{8'hF0, 8'h00, 2'd3, 3'd0, 1'b0, 8'hFF, 8'hFF};
        vt[10] = '{8'h3C, 8'h00, 2'd3, 3'd0, 1'b1, 8'h3C, 8'h3C};
        vt[11] = '{8'h12, 8'h34, 2'd0, 3'd0, 1'b0, 8'h26, 8'h3C};
        vt[12] = '{8'h96, 8'h00, 2'd2, 3'd4, 1'b0, 8'h69, 8'h3C};
        vt[13] = '{8'h40, 8'h00, 2'd1, 3'd3, 1'b0, 8'h40, 8'h3C};

        do_reset();
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset c", c, 0);
        chk("reset acc", acc, 0);
        chk("reset op_count", op_count, 0);
        chk("reset in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) run_vec(vt[i], i);

        // Backpressure: four back-to-back beats against a stalled sink.
        for (int k = 0; k < 4; k++) exp_bp[k] = 8'(8'h10 + k) ^ 8'hA5;
        n_acc = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int cy = 0; cy < 6; cy++) begin
            if (cy > 0) begin @(posedge clk); #1; end
            in_valid = (n_acc < 4); a = 8'(8'h10 + n_acc); b = 8'hA5; mode = 2'd0; shamt = 3'd0;
            @(negedge clk);
            if (in_valid && in_ready) n_acc++;
        end
        chk("bp accepts while stalled", n_acc, 2);
        chk("bp in_ready low", in_ready, 0);
        chk("bp held out_valid", out_valid, 1);
        chk("bp held c", c, exp_bp[0]);
        n_out = 0; first_cyc = -1; last_cyc = -1;
        for (int cy = 0; cy < 12 && n_out < 4; cy++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid = (n_acc < 4); a = 8'(8'h10 + n_acc); b = 8'hA5;
            @(negedge clk);
            if (in_valid && in_ready) n_acc++;
            if (out_valid && out_ready) begin
                chk($sformatf("bp result%0d", n_out), c, exp_bp[n_out]);
                if (first_cyc < 0) first_cyc = cy;
                last_cyc = cy;
                n_out++;
            end
        end
        chk("bp results seen", n_out, 4);
        chk("bp consecutive", last_cyc - first_cyc, 3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp no duplicate", out_valid, 0);

        // Random traffic against the queue model.
        @(posedge clk); #1;
        do_reset();
        q.delete();
        model_acc = 8'h00; n_acc = 0; n_out = 0; cyc = 0; prev_stall = 0; prev_c = 8'h00;
        while ((n_acc < 1000 || q.size() > 0) && cyc < 20000) begin
            @(posedge clk); #1;
            in_valid  = (n_acc < 1000) && ($urandom_range(0, 9) < 7);
            a         = 8'($urandom);
            b         = 8'($urandom);
            mode      = 2'($urandom);
            shamt     = 3'($urandom);
            out_ready = (n_acc >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                chk("rand hold valid", out_valid, 1);
                chk("rand hold c", c, prev_c);
            end
            if (in_valid && in_ready) begin
                exp_v = ref_c(a, b, mode, int'(shamt), model_acc);
                if (mode == 2'd3) model_acc = exp_v;
                q.push_back(exp_v);
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("rand unexpected output", 1, 0);
                else chk("rand c", c, q.pop_front());
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = c;
        end
        chk("rand no timeout", (cyc < 20000), 1);
        chk("rand outputs", n_out, 1000);
        chk("rand acc", acc, model_acc);
        chk("rand op_count saturated", op_count, 255);
        chk("rand op_count_sat", op_count_s, 3);

        // Asynchronous reset with two ACC beats in flight.
        n_acc = 0;
        for (int cy = 0; cy < 2; cy++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = 8'h5A; b = 8'h00; mode = 2'd3; out_ready = 1'b0;
            @(negedge clk);
            if (in_ready) n_acc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst beats accepted", n_acc, 2);
        chk("rst in flight", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst c", c, 0);
        chk("async rst acc", acc, 0);
        chk("async rst op_count", op_count, 0);
        chk("async rst op_count_sat", op_count_s, 0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst in_ready", in_ready, 1);
        seen_out = 0;
        for (int cy = 0; cy < 6; cy++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid) seen_out = 1;
        end
        chk("post rst nothing emitted", seen_out, 0);
        chk("post rst op_count", op_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
